seven_segment_decoder: RTL
==========================

Name: seven_segment_decoder

Overview:
- Receive side of the seven-segment display interface: watches a time-multiplexed segment bus and its one-hot digit-select lines.
- Filters glitches and decodes each segment pattern back to a 4-bit hex nibble.
- Assembles one nibble per digit into a frame and presents it on a valid/ack handshake.
- Used in self-checking benches and on-chip loopback to confirm that multiplier results driven to the display match the product.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (2..8)
STABLE_CYCLES, 3, consecutive identical clk samples required before a digit is captured (1..15)
SEG_ACTIVE_LOW, 0, 1 = seg_in is inverted before decoding

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
seg_in  input  7  segment pattern, bit0=a .. bit6=g, active-high unless SEG_ACTIVE_LOW
dig_sel  input  NUM_DIGITS  one-hot digit enable; bit i = digit i
frame_ack  input  1  consumer accepts current frame
err_clr  input  1  clears sticky err
frame_valid  output  1  value_out/blank_out hold a complete frame
value_out  output  4*NUM_DIGITS  decoded nibbles, digit i at [4i+3:4i]
blank_out  output  NUM_DIGITS  1 = digit i was captured as blank (pattern 0x00)
err  output  1  sticky illegal-pattern flag

Behaviour:
- Reset (rst=1 at an edge): frame_valid=0, value_out=0, blank_out=0, err=0, shadow registers=0, seen mask=0, stability counter=0, captured-latch=0. rst overrides all other inputs, including mid-frame and mid-handshake.
- Normalisation: p = SEG_ACTIVE_LOW ? ~seg_in : seg_in.
- Stability filter:
  - Register previous (p, dig_sel).
  - If the current pair equals the previous pair, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter loads 1 and the captured-latch clears.
  - A capture fires on the edge where the counter reaches STABLE_CYCLES and the captured-latch=0. That edge sets the latch, so each stable hold captures exactly once.
  - With STABLE_CYCLES=1, every changed sample captures on its first edge.
- dig_sel not one-hot (zero or more than one bit set): counter still tracks the pair, but no capture fires.
- Decode table, p in hex {g..a}:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - 00 → blank: nibble=0, blank bit=1.
- Capture of a legal pattern for digit i: shadow nibble i and shadow blank i are written, and seen[i] is set. Recapturing the same digit overwrites its shadow (latest wins).
- Capture of an illegal pattern: err is set; shadow and seen are unchanged. If err_clr is asserted on the same edge, set wins.
- err_clr alone clears err next edge.
- Frame transfer:
  - Fires on an edge where seen is all ones and (frame_valid=0 or frame_ack=1).
  - Shadow is copied to value_out/blank_out, frame_valid=1, and seen is cleared.
  - A capture on that same edge writes shadow and sets its seen bit after the clear, so it counts toward the next frame.
- Handshake:
  - frame_valid stays high and value_out is held stable until an edge with frame_ack=1.
  - On that edge frame_valid falls, unless a transfer fires on the same edge; then it stays 1 with new data (back-to-back).
  - frame_ack while frame_valid=0 is ignored.
- Backpressure: while frame_valid=1 with no ack, capturing continues into shadow. seen saturates at all ones and the newest values are transferred on ack.
- Latency: the capture edge is the STABLE_CYCLES-th edge of a stable input. For the last missing digit, frame_valid rises on the edge after its capture edge.

Test Plan:
- Reset, then drive dig_sel=0001/0010/0100/1000 with seg 0x06, 0x5B, 0x4F, 0x66, each for 3 cycles → frame_valid rises one edge after the last capture; value_out=16'h4321, blank_out=0, err=0.
- 1-cycle glitch 0x7F on digit 0 between legal 0x3F holds (STABLE_CYCLES=3) → glitch not captured; nibble 0 = 0; err=0.
- Illegal 0x01 held 5 cycles on digit 2 → err=1 after 3rd edge; seen[2] stays 0, so no frame until a legal pattern arrives. err_clr coincident with a second illegal capture → err stays 1.
- Hold frame_ack=0 for 20 cycles while a second frame (digit 0 changed to 0x77) completes → value_out unchanged until ack. On the ack edge frame_valid stays 1 and nibble 0 = A.
- dig_sel=0011 and dig_sel=0000 held 10 cycles → no capture, no frame, err=0. Pattern 0x00 on digit 3 → blank_out[3]=1, nibble 3 = 0.
- Assert rst mid-frame (2 of 4 digits seen, frame_valid=1) → next edge all outputs 0. A full new 4-digit sequence is then required for frame_valid.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// Seven-segment bus receiver: glitch-filters (seg, dig_sel), decodes to hex nibbles, assembles frames.
// Latency: capture on the STABLE_CYCLES-th stable edge; frame_valid one edge after the last capture.
// Backpressure: frame held until frame_ack; captures keep refreshing shadow, newest shadow sent on ack.
module seven_segment_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 3,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    frame_ack,
    input  logic                    err_clr,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic                    err
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    // {legal, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] pat);
        case (pat)
            7'h3F:   decode = 6'b10_0000;
            7'h06:   decode = 6'b10_0001;
            7'h5B:   decode = 6'b10_0010;
            7'h4F:   decode = 6'b10_0011;
            7'h66:   decode = 6'b10_0100;
            7'h6D:   decode = 6'b10_0101;
            7'h7D:   decode = 6'b10_0110;
            7'h07:   decode = 6'b10_0111;
            7'h7F:   decode = 6'b10_1000;
            7'h6F:   decode = 6'b10_1001;
            7'h77:   decode = 6'b10_1010;
            7'h7C:   decode = 6'b10_1011;
            7'h39:   decode = 6'b10_1100;
            7'h5E:   decode = 6'b10_1101;
            7'h79:   decode = 6'b10_1110;
            7'h71:   decode = 6'b10_1111;
            7'h00:   decode = 6'b11_0000;
            default: decode = 6'b00_0000;
        endcase
    endfunction

    logic [6:0]              prev_p_q, prev_p_d;
    logic [NUM_DIGITS-1:0]   prev_sel_q, prev_sel_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    latch_q, latch_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_blk_q, shadow_blk_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    fv_q, fv_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   blk_q, blk_d;
    logic                    err_q, err_d;

    logic [6:0] p;
    logic [5:0] dec;
    logic       same, latch_eff, fire, onehot, cap_ok, cap_bad, xfer;

    always_comb begin
        p          = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
        dec        = decode(p);
        same       = (p == prev_p_q) && (dig_sel == prev_sel_q);
        prev_p_d   = p;
        prev_sel_d = dig_sel;
        latch_eff  = same && latch_q;
        if (!same)
            cnt_d = 4'd1;
        else if (cnt_q >= STABLE)
            cnt_d = STABLE;
        else
            cnt_d = cnt_q + 4'd1;
        // A capture happens once per stable hold: the latch blocks repeats until the pair changes.
        fire    = (cnt_d == STABLE) && !latch_eff;
        latch_d = latch_eff || fire;
        onehot  = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
        cap_ok  = fire && onehot && dec[5];
        cap_bad = fire && onehot && !dec[5];

        xfer  = (&seen_q) && (!fv_q || frame_ack);
        val_d = val_q;
        blk_d = blk_q;
        fv_d  = fv_q;
        if (xfer) begin
            val_d = shadow_val_q;
            blk_d = shadow_blk_q;
            fv_d  = 1'b1;
        end else if (frame_ack) begin
            fv_d  = 1'b0;
        end

        // Seen clears on transfer first so a same-edge capture counts toward the next frame.
        seen_d       = xfer ? '0 : seen_q;
        shadow_val_d = shadow_val_q;
        shadow_blk_d = shadow_blk_q;
        if (cap_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_sel[i]) begin
                    shadow_val_d[4*i +: 4] = dec[3:0];
                    shadow_blk_d[i]        = dec[4];
                    seen_d[i]              = 1'b1;
                end
            end
        end

        if (cap_bad)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_p_q     <= '0;
            prev_sel_q   <= '0;
            cnt_q        <= '0;
            latch_q      <= 1'b0;
            shadow_val_q <= '0;
            shadow_blk_q <= '0;
            seen_q       <= '0;
            fv_q         <= 1'b0;
            val_q        <= '0;
            blk_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            prev_p_q     <= prev_p_d;
            prev_sel_q   <= prev_sel_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            shadow_val_q <= shadow_val_d;
            shadow_blk_q <= shadow_blk_d;
            seen_q       <= seen_d;
            fv_q         <= fv_d;
            val_q        <= val_d;
            blk_q        <= blk_d;
            err_q        <= err_d;
        end
    end

    assign frame_valid = fv_q;
    assign value_out   = val_q;
    assign blank_out   = blk_q;
    assign err         = err_q;

endmodule
